// File: rtl/rot_dma_ctrl.sv
// rot_dma_ctrl: DMA responder executing read/write commands as AHB-Lite INCR bursts.
// Read beats are staged in an internal FIFO and replayed by later write commands.
// Optional feature macro: ROT_DMA_STATS_EN adds O_RD_BEATS / O_WR_BEATS beat counters.
module rot_dma_ctrl #(
    parameter int FIFO_DEPTH = 16
) (
`ifdef ROT_DMA_STATS_EN
    output logic [15:0] O_RD_BEATS,
    output logic [15:0] O_WR_BEATS,
`endif
    input  logic        I_HCLK,
    input  logic        I_HRESET,
    input  logic [31:0] I_ADDR,
    input  logic [2:0]  I_SIZE,
    input  logic        I_WRITE,
    input  logic        I_BUSY,
    input  logic [4:0]  I_COUNT,
    output logic        O_DMA_READY,
    output logic        O_BUSY,
    output logic        O_ERR,
    input  logic        I_ERR_CLR,
    output logic [31:0] O_HADDR,
    output logic [1:0]  O_HTRANS,
    output logic        O_HWRITE,
    output logic [2:0]  O_HSIZE,
    output logic [2:0]  O_HBURST,
    output logic [31:0] O_HWDATA,
    input  logic [31:0] I_HRDATA,
    input  logic        I_HREADY,
    input  logic        I_HRESP
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] DEPTH32 = FIFO_DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_addr;
    logic [2:0]      r_size;
    logic            r_write;
    logic [CW-1:0]   r_beats;
    logic            r_first;
    logic            r_dphase;
    logic            r_err;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_fifo_cnt;

    logic [CW-1:0]   w_beats;
    logic [CW-1:0]   w_space;
    logic [2:0]      w_size;
    logic            w_ready;
    logic            w_accept;
    logic            w_data_err;
    logic            w_data_done;
    logic            w_addr_done;
    logic            w_push;
    logic            w_pop;

    assign w_beats = (I_COUNT == 5'd0)            ? CW'(1) :
                     ({27'd0, I_COUNT} > DEPTH32) ? DEPTH_C :
                                                    CW'(I_COUNT);
    assign w_size  = (I_SIZE > 3'd2) ? 3'd2 : I_SIZE;
    assign w_space = DEPTH_C - r_fifo_cnt;
    assign w_ready = (r_state == S_IDLE) && !r_err &&
                     (I_WRITE ? (r_fifo_cnt >= w_beats) : (w_space >= w_beats));
    assign w_accept    = I_BUSY && w_ready;
    assign w_data_err  = r_dphase && I_HRESP;
    assign w_data_done = r_dphase && I_HREADY && !I_HRESP;
    assign w_addr_done = (r_state == S_ADDR) && I_HREADY && !w_data_err;
    assign w_push      = w_data_done && !r_write && !I_ERR_CLR;
    assign w_pop       = w_data_done && r_write && !I_ERR_CLR;

    assign O_DMA_READY = w_ready;
    assign O_BUSY      = (r_state != S_IDLE);
    assign O_ERR       = r_err;
    assign O_HADDR     = r_addr;
    assign O_HWRITE    = r_write;
    assign O_HSIZE     = r_size;
    assign O_HBURST    = 3'b001;
    assign O_HTRANS    = (r_state != S_ADDR) ? 2'b00 :
                         (r_first || (r_addr[9:0] == 10'd0)) ? 2'b10 : 2'b11;
    assign O_HWDATA    = (r_dphase && r_write) ? r_mem[r_rptr] : 32'd0;

    // Burst state register; reset aborts any burst in flight.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic: address phases, trailing data phase, one-cycle error recovery.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_ADDR;
            S_ADDR: begin
                if (w_data_err)                           w_next = S_ERR;
                else if (I_HREADY && (r_beats == CW'(1))) w_next = S_LAST;
            end
            S_LAST: begin
                if (w_data_err)    w_next = S_ERR;
                else if (I_HREADY) w_next = S_IDLE;
            end
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, address sequencing, data-phase tracking and sticky error flag.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            r_addr   <= 32'd0;
            r_size   <= 3'd0;
            r_write  <= 1'b0;
            r_beats  <= '0;
            r_first  <= 1'b0;
            r_dphase <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= I_ADDR;
                r_size  <= w_size;
                r_write <= I_WRITE;
                r_beats <= w_beats;
                r_first <= 1'b1;
            end else if (w_addr_done) begin
                r_addr  <= r_addr + (32'd1 << r_size);
                r_beats <= r_beats - CW'(1);
                r_first <= 1'b0;
            end
            if (w_data_err)                              r_dphase <= 1'b0;
            else if (w_addr_done)                        r_dphase <= 1'b1;
            else if ((r_state == S_LAST) && I_HREADY)    r_dphase <= 1'b0;
            if (w_data_err)     r_err <= 1'b1;
            else if (I_ERR_CLR) r_err <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; an error clear flushes everything.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else if (I_ERR_CLR) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr     <= r_wptr + AW'(1);
                r_fifo_cnt <= r_fifo_cnt + CW'(1);
            end else if (w_pop) begin
                r_rptr     <= r_rptr + AW'(1);
                r_fifo_cnt <= r_fifo_cnt - CW'(1);
            end
        end
    end

    // FIFO storage captures read data on each completed read beat.
    always_ff @(posedge I_HCLK) begin
        if (w_push) r_mem[r_wptr] <= I_HRDATA;
    end

`ifdef ROT_DMA_STATS_EN
    // Free-running completed-beat counters per direction.
    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            O_RD_BEATS <= 16'd0;
            O_WR_BEATS <= 16'd0;
        end else if (w_data_done) begin
            if (r_write) O_WR_BEATS <= O_WR_BEATS + 16'd1;
            else         O_RD_BEATS <= O_RD_BEATS + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rot_dma_ctrl.sv
// tb_rot_dma_ctrl: directed self-checking bench for rot_dma_ctrl with a simple AHB slave
// whose read data is derived from the address of the beat being returned.
module tb_rot_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] I_ADDR;
    logic [2:0]  I_SIZE;
    logic        I_WRITE;
    logic        I_BUSY;
    logic [4:0]  I_COUNT;
    logic        O_DMA_READY;
    logic        O_BUSY;
    logic        O_ERR;
    logic        I_ERR_CLR;
    logic [31:0] O_HADDR;
    logic [1:0]  O_HTRANS;
    logic        O_HWRITE;
    logic [2:0]  O_HSIZE;
    logic [2:0]  O_HBURST;
    logic [31:0] O_HWDATA;
    logic [31:0] I_HRDATA;
    logic        I_HREADY;
    logic        I_HRESP;
`ifdef ROT_DMA_STATS_EN
    logic [15:0] O_RD_BEATS;
    logic [15:0] O_WR_BEATS;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] slaveAddr;

    rot_dma_ctrl #(.FIFO_DEPTH(16)) dut (
`ifdef ROT_DMA_STATS_EN
        .O_RD_BEATS(O_RD_BEATS),
        .O_WR_BEATS(O_WR_BEATS),
`endif
        .I_HCLK(clk), .I_HRESET(rst), .I_ADDR(I_ADDR), .I_SIZE(I_SIZE),
        .I_WRITE(I_WRITE), .I_BUSY(I_BUSY), .I_COUNT(I_COUNT),
        .O_DMA_READY(O_DMA_READY), .O_BUSY(O_BUSY), .O_ERR(O_ERR),
        .I_ERR_CLR(I_ERR_CLR), .O_HADDR(O_HADDR), .O_HTRANS(O_HTRANS),
        .O_HWRITE(O_HWRITE), .O_HSIZE(O_HSIZE), .O_HBURST(O_HBURST),
        .O_HWDATA(O_HWDATA), .I_HRDATA(I_HRDATA), .I_HREADY(I_HREADY),
        .I_HRESP(I_HRESP)
    );

    always #5 clk = ~clk;

    // Slave model: remember the accepted address phase and return data for it next cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) slaveAddr <= 32'd0;
        else if (I_HREADY && O_HTRANS[1]) slaveAddr <= O_HADDR;
    end
    assign I_HRDATA = slaveAddr ^ 32'hC0DE0000;

    function automatic logic [31:0] rdWord(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    task automatic issueCmd(input logic [31:0] a, input logic w, input logic [4:0] c, input logic [2:0] s);
        I_ADDR = a; I_WRITE = w; I_COUNT = c; I_SIZE = s; I_BUSY = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; I_ADDR = 0; I_SIZE = 3'd2; I_WRITE = 0; I_BUSY = 0; I_COUNT = 1;
        I_ERR_CLR = 0; I_HREADY = 1; I_HRESP = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (O_HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL rst_htrans got=%b exp=00", O_HTRANS); end
        checks++; if (O_HADDR !== 32'd0) begin errors++; $display("[TB] FAIL rst_haddr got=%h exp=0", O_HADDR); end
        checks++; if (O_HWDATA !== 32'd0) begin errors++; $display("[TB] FAIL rst_hwdata got=%h exp=0", O_HWDATA); end
        checks++; if ({O_HSIZE, O_HWRITE} !== 4'd0) begin errors++; $display("[TB] FAIL rst_ctrl got=%h exp=0", {O_HSIZE, O_HWRITE}); end
        checks++; if (O_HBURST !== 3'b001) begin errors++; $display("[TB] FAIL rst_hburst got=%b exp=001", O_HBURST); end
        checks++; if ({O_BUSY, O_ERR} !== 2'b00) begin errors++; $display("[TB] FAIL rst_busy_err got=%b exp=00", {O_BUSY, O_ERR}); end
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=1", O_DMA_READY); end
    endtask

    task automatic test_read_burst;
        @(negedge clk);
        issueCmd(32'h100, 1'b0, 5'd4, 3'd2);
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready got=%b exp=1", O_DMA_READY); end
        @(negedge clk); I_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (O_HTRANS !== ((i == 0) ? 2'b10 : 2'b11)) begin errors++; $display("[TB] FAIL rd_htrans%0d got=%b", i, O_HTRANS); end
            checks++; if (O_HADDR !== 32'h100 + 32'(4 * i)) begin errors++; $display("[TB] FAIL rd_haddr%0d got=%h exp=%h", i, O_HADDR, 32'h100 + 32'(4 * i)); end
            @(negedge clk);
        end
        checks++; if ({O_HTRANS, O_BUSY} !== 3'b001) begin errors++; $display("[TB] FAIL rd_last got=%b exp=001", {O_HTRANS, O_BUSY}); end
        @(negedge clk);
        checks++; if (O_BUSY !== 1'b0) begin errors++; $display("[TB] FAIL rd_done_busy got=%b exp=0", O_BUSY); end
        checks++; if (dut.r_fifo_cnt !== 5'd4) begin errors++; $display("[TB] FAIL rd_fifo_cnt got=%0d exp=4", dut.r_fifo_cnt); end
    endtask

    task automatic test_write_replay;
        issueCmd(32'h200, 1'b1, 5'd4, 3'd2);
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL wr_ready got=%b exp=1", O_DMA_READY); end
        @(negedge clk); I_BUSY = 1'b0;
        checks++; if ({O_HTRANS, O_HWRITE} !== 3'b101 || O_HADDR !== 32'h200) begin errors++; $display("[TB] FAIL wr_first got=%b/%h exp=101/200", {O_HTRANS, O_HWRITE}, O_HADDR); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (O_HWDATA !== rdWord(32'h100 + 32'(4 * i))) begin errors++; $display("[TB] FAIL wr_hwdata%0d got=%h exp=%h", i, O_HWDATA, rdWord(32'h100 + 32'(4 * i))); end
        end
        @(negedge clk);
        checks++; if (O_BUSY !== 1'b0 || dut.r_fifo_cnt !== 5'd0) begin errors++; $display("[TB] FAIL wr_done got=%b/%0d exp=0/0", O_BUSY, dut.r_fifo_cnt); end
    endtask

    task automatic test_stall_write;
        issueCmd(32'h500, 1'b1, 5'd2, 3'd2);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({O_DMA_READY, O_HTRANS} !== 3'b000) begin errors++; $display("[TB] FAIL stall%0d got=%b exp=000", i, {O_DMA_READY, O_HTRANS}); end
            @(negedge clk); #1;
        end
        issueCmd(32'h300, 1'b0, 5'd2, 3'd7);
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL stall_rd_ready got=%b exp=1", O_DMA_READY); end
        @(negedge clk); I_BUSY = 1'b0;
        checks++; if (O_HSIZE !== 3'd2 || O_HADDR !== 32'h300) begin errors++; $display("[TB] FAIL stall_rd_size got=%0d/%h exp=2/300", O_HSIZE, O_HADDR); end
        @(negedge clk);
        checks++; if (O_HADDR !== 32'h304) begin errors++; $display("[TB] FAIL stall_rd_step got=%h exp=304", O_HADDR); end
        repeat (2) @(negedge clk);
        issueCmd(32'h500, 1'b1, 5'd2, 3'd2);
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL stall_wr_ready got=%b exp=1", O_DMA_READY); end
        @(negedge clk); I_BUSY = 1'b0;
        checks++; if (O_HTRANS !== 2'b10 || O_HADDR !== 32'h500) begin errors++; $display("[TB] FAIL stall_wr_go got=%b/%h exp=10/500", O_HTRANS, O_HADDR); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (O_HWDATA !== rdWord(32'h300 + 32'(4 * i))) begin errors++; $display("[TB] FAIL stall_wr_data%0d got=%h exp=%h", i, O_HWDATA, rdWord(32'h300 + 32'(4 * i))); end
        end
        @(negedge clk);
    endtask

    task automatic test_single_and_clamp;
        issueCmd(32'h800, 1'b0, 5'd31, 3'd2);
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL clamp_ready got=%b exp=1", O_DMA_READY); end
        I_COUNT = 5'd0; #1;
        @(negedge clk); I_BUSY = 1'b0;
        checks++; if (O_HTRANS !== 2'b10) begin errors++; $display("[TB] FAIL single_nonseq got=%b exp=10", O_HTRANS); end
        @(negedge clk);
        checks++; if ({O_HTRANS, O_BUSY} !== 3'b001) begin errors++; $display("[TB] FAIL single_last got=%b exp=001", {O_HTRANS, O_BUSY}); end
        @(negedge clk);
        checks++; if (O_BUSY !== 1'b0 || dut.r_fifo_cnt !== 5'd1) begin errors++; $display("[TB] FAIL single_done got=%b/%0d exp=0/1", O_BUSY, dut.r_fifo_cnt); end
        I_WRITE = 1'b1; I_COUNT = 5'd2; #1;
        checks++; if (O_DMA_READY !== 1'b0) begin errors++; $display("[TB] FAIL wr2_ready got=%b exp=0", O_DMA_READY); end
        issueCmd(32'h900, 1'b1, 5'd1, 3'd2);
        checks++; if (O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL wr1_ready got=%b exp=1", O_DMA_READY); end
        @(negedge clk); I_BUSY = 1'b0;
        @(negedge clk);
        checks++; if (O_HWDATA !== rdWord(32'h800)) begin errors++; $display("[TB] FAIL wr1_data got=%h exp=%h", O_HWDATA, rdWord(32'h800)); end
        @(negedge clk);
    endtask

    task automatic test_boundary_wait;
        issueCmd(32'h3F8, 1'b0, 5'd4, 3'd2);
        @(negedge clk); I_BUSY = 1'b0;
        checks++; if (O_HTRANS !== 2'b10 || O_HADDR !== 32'h3F8) begin errors++; $display("[TB] FAIL bnd_b1 got=%b/%h exp=10/3f8", O_HTRANS, O_HADDR); end
        @(negedge clk);
        checks++; if (O_HTRANS !== 2'b11 || O_HADDR !== 32'h3FC) begin errors++; $display("[TB] FAIL bnd_b2 got=%b/%h exp=11/3fc", O_HTRANS, O_HADDR); end
        I_HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (O_HTRANS !== 2'b11 || O_HADDR !== 32'h3FC || dut.r_fifo_cnt !== 5'd0) begin errors++; $display("[TB] FAIL bnd_hold%0d got=%b/%h/%0d exp=11/3fc/0", i, O_HTRANS, O_HADDR, dut.r_fifo_cnt); end
        end
        I_HREADY = 1'b1;
        @(negedge clk);
        checks++; if (O_HTRANS !== 2'b10 || O_HADDR !== 32'h400) begin errors++; $display("[TB] FAIL bnd_1k got=%b/%h exp=10/400", O_HTRANS, O_HADDR); end
        @(negedge clk);
        checks++; if (O_HTRANS !== 2'b11 || O_HADDR !== 32'h404) begin errors++; $display("[TB] FAIL bnd_b4 got=%b/%h exp=11/404", O_HTRANS, O_HADDR); end
        repeat (2) @(negedge clk);
        checks++; if (dut.r_fifo_cnt !== 5'd4) begin errors++; $display("[TB] FAIL bnd_cnt got=%0d exp=4", dut.r_fifo_cnt); end
        issueCmd(32'hA00, 1'b1, 5'd4, 3'd2);
        @(negedge clk); I_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (O_HWDATA !== rdWord(32'h3F8 + 32'(4 * i))) begin errors++; $display("[TB] FAIL bnd_data%0d got=%h exp=%h", i, O_HWDATA, rdWord(32'h3F8 + 32'(4 * i))); end
        end
        @(negedge clk);
    endtask

    task automatic test_error;
        issueCmd(32'h600, 1'b0, 5'd4, 3'd2);
        @(negedge clk); I_BUSY = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (O_HTRANS !== 2'b11 || O_HADDR !== 32'h608) begin errors++; $display("[TB] FAIL err_pre got=%b/%h exp=11/608", O_HTRANS, O_HADDR); end
        I_HRESP = 1'b1;
        @(negedge clk);
        I_HRESP = 1'b0;
        checks++; if (O_HTRANS !== 2'b00 || O_ERR !== 1'b1) begin errors++; $display("[TB] FAIL err_cycle got=%b/%b exp=00/1", O_HTRANS, O_ERR); end
        @(negedge clk);
        checks++; if (O_BUSY !== 1'b0 || dut.r_fifo_cnt !== 5'd1) begin errors++; $display("[TB] FAIL err_idle got=%b/%0d exp=0/1", O_BUSY, dut.r_fifo_cnt); end
        checks++; if (O_DMA_READY !== 1'b0 || O_ERR !== 1'b1) begin errors++; $display("[TB] FAIL err_block got=%b/%b exp=0/1", O_DMA_READY, O_ERR); end
        I_ERR_CLR = 1'b1;
        @(negedge clk);
        I_ERR_CLR = 1'b0; #1;
        checks++; if (O_ERR !== 1'b0 || dut.r_fifo_cnt !== 5'd0 || O_DMA_READY !== 1'b1) begin errors++; $display("[TB] FAIL err_clr got=%b/%0d/%b exp=0/0/1", O_ERR, dut.r_fifo_cnt, O_DMA_READY); end
    endtask

    task automatic test_reset_midburst;
        @(negedge clk);
        issueCmd(32'h700, 1'b0, 5'd4, 3'd2);
        @(negedge clk); I_BUSY = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (O_HTRANS !== 2'b00 || O_BUSY !== 1'b0 || dut.r_fifo_cnt !== 5'd0) begin errors++; $display("[TB] FAIL mid_rst got=%b/%b/%0d exp=00/0/0", O_HTRANS, O_BUSY, dut.r_fifo_cnt); end
`ifdef ROT_DMA_STATS_EN
        checks++; if (O_RD_BEATS !== 16'd0 || O_WR_BEATS !== 16'd0) begin errors++; $display("[TB] FAIL mid_stats got=%0d/%0d exp=0/0", O_RD_BEATS, O_WR_BEATS); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_read_burst();
        test_write_replay();
        test_stall_write();
        test_single_and_clamp();
        test_boundary_wait();
        test_error();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
